// File: rtl/mux_16_rr_arbiter_pkg.sv
// Shared sizes, FSM state type and small helpers for the 16-way round-robin mux arbiter.
package mux_16_rr_arbiter_pkg;

  localparam int NUM_REQ = 16;
  localparam int SEL_W   = 4;
  localparam int HOLD_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux_16_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter that drives the shared mux.
interface mux_16_rr_arbiter_if;
  import mux_16_rr_arbiter_pkg::*;

  logic [NUM_REQ-1:0] Request_In;
  logic [NUM_REQ-1:0] Grant_Out;
  logic [SEL_W-1:0]   Select_Out;
  logic               Enable_Out;
  logic [HOLD_W-1:0]  Hold_Count_Out;

  modport master (
    output Request_In,
    input  Grant_Out,
    input  Select_Out,
    input  Enable_Out,
    input  Hold_Count_Out
  );

  modport slave (
    input  Request_In,
    output Grant_Out,
    output Select_Out,
    output Enable_Out,
    output Hold_Count_Out
  );

endinterface

// File: rtl/mux_16_rr_arbiter_rr_pick_16.sv
// Combinational rotating-priority search: first set request at or after start, wrapping 15 -> 0.
module rr_pick_16
  import mux_16_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   start,
  output logic               found,
  output logic [SEL_W-1:0]   win
);

  logic [SEL_W-1:0] cand;

  // NOTE: every signal written here gets a default before the loop; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = start + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_16_rr_arbiter.sv
// Round-robin owner of a shared 16:1 mux path with a hold-time limit; all outputs registered.
module mux_16_rr_arbiter
  import mux_16_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic               Clock_In,
  input logic               Reset_In,
  mux_16_rr_arbiter_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic [SEL_W-1:0]   last_q,  last_d;
  logic               en_q,    en_d;
  logic [HOLD_W-1:0]  hold_q,  hold_d;

  logic [SEL_W-1:0]   start;
  logic [SEL_W-1:0]   win;
  logic               found;
  logic               owner_req;
  logic               others;
  logic               at_limit;
  logic               do_pick;

  // Search always begins just past the last winner; in GRANT that is the owner itself.
  assign start = last_q + SEL_W'(1);

  rr_pick_16 u_pick (
    .req   (bus.Request_In),
    .start (start),
    .found (found),
    .win   (win)
  );

  assign owner_req = bus.Request_In[sel_q];
  assign others    = |(bus.Request_In & ~grant_q);
  assign at_limit  = (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    en_d    = en_q;
    hold_d  = hold_q;
    last_d  = last_q;
    do_pick = 1'b0;

    unique case (state_q)
      IDLE: do_pick = 1'b1;
      GRANT: begin
        if (!owner_req || (at_limit && others)) begin
          do_pick = 1'b1;
        end else if (at_limit) begin
          hold_d = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: do_pick = 1'b1;
    endcase

    // A released owner has its bit low, so it drops out of the search naturally;
    // a preempted owner stays eligible but sits last in the rotation.
    if (do_pick) begin
      if (found) begin
        state_d = GRANT;
        sel_d   = win;
        grant_d = sel_to_onehot(win);
        en_d    = 1'b1;
        hold_d  = '0;
        last_d  = win;
      end else begin
        state_d = IDLE;
        sel_d   = '0;
        grant_d = '0;
        en_d    = 1'b0;
        hold_d  = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      hold_q  <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign bus.Grant_Out      = grant_q;
  assign bus.Select_Out     = sel_q;
  assign bus.Enable_Out     = en_q;
  assign bus.Hold_Count_Out = hold_q;

endmodule
